// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line levels.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// `clear` restarts the period so the owning FSM gets a full bit time after each state entry.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Period counter; wraps on its own at the period end so consecutive bits need no clear.
  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead FIFO; 8N1 frames, LSB first, back-to-back
// when the FIFO still holds data at the end of STOP.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | line high, waiting for the FIFO to become non-empty
//   START    | start bit (low) for one bit period
//   DATA     | data bits, shift register bit 0 on the line
//   PARITY   | even parity of the latched byte (parity build only)
//   STOP     | stop bit (high); last cycle pops the next byte if present
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_ren,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_tx_state_t        state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_idx;
  logic                  tick;
  logic                  load;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // The counter is held at zero in IDLE; every other state entry lands on a period wrap.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  // Pops must be visible in the same cycle the byte is latched, so these are decoded
  // from state; reset gates them so nothing is popped while reset is held.
  assign load       = !reset && !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && tick));
  assign fifo_ren   = load;
  assign frame_done = !reset && (state == ST_STOP) && tick;

  // Frame sequencer; tx and busy are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx        <= UART_IDLE_LEVEL;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state     <= ST_START;
            tx        <= UART_START_LEVEL;
            busy      <= 1'b1;
            shift_reg <= fifo_data;
            bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_data;
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            tx    <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity_bit;
`else
              state <= ST_STOP;
              tx    <= UART_STOP_LEVEL;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            tx    <= UART_STOP_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (load) begin
              state     <= ST_START;
              tx        <= UART_START_LEVEL;
              shift_reg <= fifo_data;
              bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^fifo_data;
`endif
            end else begin
              state <= ST_IDLE;
              tx    <= UART_IDLE_LEVEL;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= UART_IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: behavioural show-ahead FIFO, directed stimulus, and a
// line monitor that checks each frame against a queue of expected bytes.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = 44;
  localparam bit PAR_EN    = 1'b1;
`else
  localparam int FRAME_LEN = 40;
  localparam bit PAR_EN    = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_ren;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int frames_seen = 0;
  int pop_cnt = 0;
  int bad_pop = 0;

  sb_t        sbq[$];
  logic [7:0] fq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_drain #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_ren  (fifo_ren),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Show-ahead FIFO model: head and empty flag update on the clock edge.
  always @(posedge clk) begin
    if (fifo_ren && fq.size() != 0) void'(fq.pop_front());
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() != 0) ? fq[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (fifo_ren) pop_cnt <= pop_cnt + 1;
    if (fifo_ren && fifo_empty) bad_pop <= bad_pop + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p, input bit b2b);
    sb_t e;
    e.data = d;
    e.par  = p;
    e.b2b  = b2b;
    sbq.push_back(e);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (frames_seen < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, frames_seen, n);
  endtask

  // Line monitor: follows every pop through its frame, cycle by cycle.
  initial begin : monitor
    sb_t        e;
    logic [7:0] rx;
    logic       rx_par;
    logic       exp_lvl;
    int         line_err, busy_err, ren_err, fd_cnt, fd_off, pop_cyc, prev_end, j;
    bit         aborted;
    prev_end = -1000;
    @(negedge clk);
    forever begin
      while (!(fifo_ren && !reset)) @(negedge clk);
      pop_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        e.data = 8'h00;
        e.par  = 1'b0;
        e.b2b  = 1'b0;
      end else begin
        e = sbq.pop_front();
      end
      if (e.b2b) chk("b2b_gap", pop_cyc - prev_end, 0);
      rx = 8'h00; rx_par = 1'b0;
      line_err = 0; busy_err = 0; ren_err = 0; fd_cnt = 0; fd_off = 0;
      aborted = 1'b0;
      for (int k = 1; k <= FRAME_LEN; k++) begin
        @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        j = (k - 1) / CPB;
        if (j == 0) exp_lvl = 1'b0;
        else if (j <= 8) exp_lvl = e.data[j-1];
        else if (PAR_EN && j == 9) exp_lvl = e.par;
        else exp_lvl = 1'b1;
        if (tx !== exp_lvl) line_err++;
        if (k % CPB == 2) begin
          if (j >= 1 && j <= 8) rx[j-1] = tx;
          else if (PAR_EN && j == 9) rx_par = tx;
        end
        if (busy !== 1'b1) busy_err++;
        if (frame_done) begin
          fd_cnt++;
          fd_off = k;
        end
        if (fifo_ren && k < FRAME_LEN) ren_err++;
      end
      if (!aborted) begin
        chk("rx_byte", rx, e.data);
        chk("line_shape_errs", line_err, 0);
        chk("busy_in_frame_errs", busy_err, 0);
        chk("early_pop_errs", ren_err, 0);
        chk("frame_done_offset", (fd_cnt == 1) ? fd_off : 999, FRAME_LEN);
`ifdef UART_TX_PARITY_EN
        chk("parity_bit", rx_par, e.par);
`endif
        frames_seen++;
        prev_end = pop_cyc + FRAME_LEN;
      end
    end
  end

  initial begin : main
    int ren_cnt, low_cnt, busy_cnt, i;

    // Reset with an empty FIFO, then 50 idle cycles.
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ren", fifo_ren, 0);
    chk("rst_frame_done", frame_done, 0);
    step();
    reset = 1'b0;
    ren_cnt = 0; low_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (fifo_ren) ren_cnt++;
      if (!tx) low_cnt++;
      if (busy) busy_cnt++;
    end
    chk("idle_ren_pulses", ren_cnt, 0);
    chk("idle_tx_low_cycles", low_cnt, 0);
    chk("idle_busy_cycles", busy_cnt, 0);

    // Single byte A5 (four ones: even parity 0).
    step();
    expect_frame(8'hA5, 1'b0, 1'b0);
    write_byte(8'hA5);
    wait_frames(1, 100, "single_frames");
    @(negedge clk);
    chk("single_busy_after", busy, 0);
    chk("single_tx_after", tx, 1);
    chk("single_fifo_depth", fq.size(), 0);
    chk("single_pop_count", pop_cnt, 1);

    // Three frames back to back.
    step();
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b1);
    expect_frame(8'h3C, 1'b0, 1'b1);
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h3C);
    wait_frames(4, 200, "b2b_frames");
    @(negedge clk);
    chk("b2b_fifo_depth", fq.size(), 0);
    chk("b2b_pop_count", pop_cnt, 4);
    chk("b2b_busy_after", busy, 0);

    // Parity cases: 07 has three ones, 03 has two.
    step();
    expect_frame(8'h07, 1'b1, 1'b0);
    write_byte(8'h07);
    wait_frames(5, 100, "par07_frames");
    step();
    expect_frame(8'h03, 1'b0, 1'b0);
    write_byte(8'h03);
    wait_frames(6, 100, "par03_frames");

    // Reset during data bit 3 of 55 while 12 is being queued.
    step();
    expect_frame(8'h55, 1'b0, 1'b0);
    write_byte(8'h55);
    i = 0;
    @(negedge clk);
    while (!fifo_ren && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("pop_55", fifo_ren, 1);
    repeat (17) @(negedge clk);
    chk("bit3_of_55", tx, 0);
    step();
    reset = 1'b1;
    expect_frame(8'h12, 1'b0, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'h12;
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ren", fifo_ren, 0);
    chk("midrst_frame_done", frame_done, 0);
    step();
    reset = 1'b0;
    wait_frames(7, 100, "after_rst_frames");
    repeat (60) @(negedge clk);
    chk("no_resend_frames", frames_seen, 7);
    chk("no_resend_pops", pop_cnt, 8);
    chk("after_rst_sb_left", sbq.size(), 0);
    chk("after_rst_fifo_depth", fq.size(), 0);

    // FIFO empty at the end of STOP, written shortly after.
    step();
    expect_frame(8'h3A, 1'b0, 1'b0);
    write_byte(8'h3A);
    i = 0;
    @(negedge clk);
    while (!frame_done && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("late_first_done", frame_done, 1);
    step();
    @(negedge clk);
    chk("late_idle_busy", busy, 0);
    chk("late_idle_tx", tx, 1);
    chk("late_idle_ren", fifo_ren, 0);
    expect_frame(8'h81, 1'b0, 1'b0);
    step();
    wr_en   = 1'b1;
    wr_data = 8'h81;
    @(negedge clk);
    chk("late_ren_before_write", fifo_ren, 0);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("late_ren_first_nonempty", fifo_ren, 1);
    chk("late_busy_at_pop", busy, 0);
    @(negedge clk);
    chk("late_start_tx", tx, 0);
    chk("late_start_busy", busy, 1);
    wait_frames(9, 100, "late_frames");
    repeat (5) @(negedge clk);
    chk("final_pop_count", pop_cnt, 10);
    chk("final_bad_pops", bad_pop, 0);
    chk("final_sb_left", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
